// File: rtl/dlfloat_operand_loader.sv
// rtl/dlfloat_operand_loader.sv - byte-stream to DLFloat operand-pair loader with vector framing
// Optional sticky special-value flag: define DLFLOAT_SPECIAL_FLAG_EN.
module dlfloat_operand_loader #(
    parameter int          LEN_W       = 8,
    parameter logic [15:0] SPECIAL_VAL = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             acc_clr,
    output logic             op_last,
    output logic             busy,
    output logic             done,
`ifdef DLFLOAT_SPECIAL_FLAG_EN
    output logic             special_seen,
`endif
    output logic [LEN_W-1:0] pair_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_LO  = 3'd1,
        A_HI  = 3'd2,
        B_LO  = 3'd3,
        B_HI  = 3'd4,
        ISSUE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic             start_acc;
    logic             byte_acc;
    logic             handshake;
    logic             is_last;

    // len_q of 0 wraps to all-ones, so a zero length frames 2^LEN_W pairs
    assign is_last   = (pair_cnt == (len_q - LEN_W'(1)));
    assign start_acc = (state == IDLE) && start;
    assign byte_acc  = byte_valid && byte_ready && !abort;
    assign handshake = op_valid && op_ready && !abort;

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        op_valid   = 1'b0;
        acc_clr    = 1'b0;
        op_last    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = A_LO;
            end
            A_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = A_HI;
            end
            A_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = B_LO;
            end
            B_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = B_HI;
            end
            B_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                op_valid = 1'b1;
                acc_clr  = (pair_cnt == '0);
                op_last  = is_last;
                if (op_ready) state_nxt = is_last ? DONE : A_LO;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            pair_cnt <= '0;
            len_q    <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                len_q    <= vec_len;
                pair_cnt <= '0;
            end
            if (handshake) pair_cnt <= pair_cnt + LEN_W'(1);
            if (byte_acc) begin
                case (state)
                    A_LO:    op_a[7:0]  <= byte_in;
                    A_HI:    op_a[15:8] <= byte_in;
                    B_LO:    op_b[7:0]  <= byte_in;
                    B_HI:    op_b[15:8] <= byte_in;
                    default: ;
                endcase
            end
        end
    end

`ifdef DLFLOAT_SPECIAL_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            special_seen <= 1'b0;
        end else if (handshake && ((op_a == SPECIAL_VAL) || (op_b == SPECIAL_VAL))) begin
            special_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// tb/tb_dlfloat_operand_loader.sv - randomized self-checking bench for dlfloat_operand_loader
module tb_dlfloat_operand_loader;

    localparam int LEN_W = 8;
    localparam int NMAX  = 1 << LEN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] vec_len;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_valid;
    logic             op_ready;
    logic             acc_clr;
    logic             op_last;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] pair_cnt;
`ifdef DLFLOAT_SPECIAL_FLAG_EN
    logic             special_seen;
`endif

    int errors = 0;
    int checks = 0;
    logic exp_special;

    always #5 clk = ~clk;

    dlfloat_operand_loader #(.LEN_W(LEN_W), .SPECIAL_VAL(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_len(vec_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .acc_clr(acc_clr), .op_last(op_last), .busy(busy), .done(done),
`ifdef DLFLOAT_SPECIAL_FLAG_EN
        .special_seen(special_seen),
`endif
        .pair_cnt(pair_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic feed_pair(input logic [15:0] a, input logic [15:0] b);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    // gap_mode: 0 back-to-back, 1 random gaps, 2 every other cycle
    // stall_pair: -1 random stalls, -2 none, else stall only that pair index
    task automatic run_vector(input int len, input int gap_mode, input int stall_pair,
                              input int stall_cycles, input logic force_first,
                              input logic [15:0] fa, input logic [15:0] fb);
        int n;
        int gaps;
        int st;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  bytes [4];
        n = (len == 0) ? NMAX : len;
        vec_len = len[LEN_W-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        vec_len = LEN_W'($urandom);
        exp_special = 1'b0;
        check("busy_after_start", busy, 1);
        check("pair_cnt_cleared", pair_cnt, 0);
`ifdef DLFLOAT_SPECIAL_FLAG_EN
        check("special_cleared_on_start", special_seen, 0);
`endif
        for (int p = 0; p < n; p++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
            if (force_first && p == 0) begin
                a = fa;
                b = fb;
            end
            bytes[0] = a[7:0];
            bytes[1] = a[15:8];
            bytes[2] = b[7:0];
            bytes[3] = b[15:8];
            for (int k = 0; k < 4; k++) begin
                gaps = (gap_mode == 0) ? 0 : (gap_mode == 2) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    step();
                    check("gap_byte_ready", byte_ready, 1);
                    check("gap_no_valid", op_valid, 0);
                end
                send_byte(bytes[k]);
            end
            check("issue_valid", op_valid, 1);
            check("issue_op_a", op_a, a);
            check("issue_op_b", op_b, b);
            check("issue_acc_clr", acc_clr, (p == 0));
            check("issue_op_last", op_last, (p == n - 1));
            check("issue_byte_ready", byte_ready, 0);
            if (p == stall_pair) st = stall_cycles;
            else if (stall_pair == -1) st = int'($urandom_range(0, 2));
            else st = 0;
            for (int s = 0; s < st; s++) begin
                op_ready = 1'b0;
                step();
                check("stall_valid", op_valid, 1);
                check("stall_op_a", op_a, a);
                check("stall_op_b", op_b, b);
                check("stall_byte_ready", byte_ready, 0);
            end
            op_ready = 1'b1;
            step();
            op_ready = 1'b0;
            if (a == 16'hFFFF || b == 16'hFFFF) exp_special = 1'b1;
            check("pair_cnt_after_hs", pair_cnt, (p + 1) % NMAX);
            if (p < n - 1) begin
                check("mid_no_done", done, 0);
                check("mid_no_valid", op_valid, 0);
            end
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
`ifdef DLFLOAT_SPECIAL_FLAG_EN
        check("special_at_done", special_seen, exp_special);
`endif
        step();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_pair_cnt", pair_cnt, n % NMAX);
`ifdef DLFLOAT_SPECIAL_FLAG_EN
        check("special_in_idle", special_seen, exp_special);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; vec_len = 8'd1;
        byte_in = '0; byte_valid = 1'b0; op_ready = 1'b0;
        step();
        step();
        start = 1'b0;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_done", done, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_op_last", op_last, 0);

        run_vector(1, 0, -2, 0, 1'b1, 16'h3E00, 16'h4000);
        run_vector(3, 0, 1, 4, 1'b0, 16'h0, 16'h0);
        run_vector(4, 2, -2, 0, 1'b0, 16'h0, 16'h0);
        for (int v = 0; v < 6; v++) run_vector(int'($urandom_range(1, 6)), 1, -1, 0, 1'b0, 16'h0, 16'h0);
        run_vector(0, 0, -2, 0, 1'b0, 16'h0, 16'h0);

        // abort while in B_LO: no done, stale op_a kept
        vec_len = 8'd1; start = 1'b1; step(); start = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_byte_ready", byte_ready, 0);
        check("abort_stale_a", op_a, 16'h2211);
        step();
        check("abort_still_no_done", done, 0);
        run_vector(1, 0, -2, 0, 1'b1, 16'hABCD, 16'h1234);

        // abort coinciding with op_ready is not counted
        vec_len = 8'd2; start = 1'b1; step(); start = 1'b0;
        feed_pair(16'h5555, 16'h6666);
        check("abort_hs_valid", op_valid, 1);
        op_ready = 1'b1; abort = 1'b1; step(); op_ready = 1'b0; abort = 1'b0;
        check("abort_hs_pair_cnt", pair_cnt, 0);
        check("abort_hs_busy", busy, 0);
        check("abort_hs_no_done", done, 0);

        // reset in ISSUE
        vec_len = 8'd2; start = 1'b1; step(); start = 1'b0;
        feed_pair(16'h7777, 16'h8888);
        check("pre_rst_valid", op_valid, 1);
        rst = 1'b1; abort = 1'b1; step(); rst = 1'b0; abort = 1'b0;
        check("issue_rst_valid", op_valid, 0);
        check("issue_rst_busy", busy, 0);
        check("issue_rst_op_a", op_a, 0);
        check("issue_rst_op_b", op_b, 0);
        check("issue_rst_pair_cnt", pair_cnt, 0);

        run_vector(2, 0, -2, 0, 1'b1, 16'h1234, 16'hFFFF);
        run_vector(1, 0, -2, 0, 1'b1, 16'h0101, 16'h0202);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlfloat_operand_loader.md
Name: dlfloat_operand_loader

Overview:
- Upstream stage of the DLFloat MAC.
- Receives operands as a byte stream on the 8-bit pin interface and assembles them into 16-bit DLFloat operand pairs (a, b).
- Issues each pair to the MAC with a valid/ready handshake.
- Frames a dot-product vector of programmable length: requests an accumulator clear with the first pair, flags the last pair, and pulses done when the vector completes.

Parameters:
- LEN_W, 8, width of vector-length field and pair counter; vec_len = 0 means 2^LEN_W pairs.
- SPECIAL_VAL, 16'hFFFF, DLFloat saturate/special encoding recognised by the optional flag logic.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a new vector; sampled only in IDLE
- abort  input  1  synchronous abort of the current vector
- vec_len  input  LEN_W  number of (a,b) pairs in the vector; latched on accepted start
- byte_in  input  8  operand byte stream, little-endian per operand
- byte_valid  input  1  byte_in holds a valid byte
- byte_ready  output  1  loader accepts byte this cycle
- op_a  output  16  assembled operand a
- op_b  output  16  assembled operand b
- op_valid  output  1  op_a/op_b valid to MAC
- op_ready  input  1  MAC accepts the pair
- acc_clr  output  1  qualifies op_valid: first pair of vector, MAC restarts accumulation
- op_last  output  1  qualifies op_valid: final pair of vector
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last pair handshake
- pair_cnt  output  LEN_W  pairs issued so far in current vector

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. byte_ready, op_valid, acc_clr, op_last, busy and done are 0. op_a, op_b and pair_cnt are 0. Latched length is 0. Reset overrides abort and start.
- States: IDLE, A_LO, A_HI, B_LO, B_HI, ISSUE, DONE.
- IDLE: byte_ready=0. When start=1, latch vec_len, clear pair_cnt, go to A_LO. start in any other state is ignored.
- A_LO/A_HI/B_LO/B_HI: byte_ready=1. A byte is accepted when byte_valid & byte_ready.
  - A_LO accept: op_a[7:0] <= byte_in.
  - A_HI accept: op_a[15:8] <= byte_in.
  - B_LO accept: op_b[7:0] <= byte_in.
  - B_HI accept: op_b[15:8] <= byte_in.
  - Each accept advances to the next state; B_HI advances to ISSUE.
  - With byte_valid=0 the state holds.
- ISSUE: byte_ready=0, op_valid=1. op_a, op_b, acc_clr and op_last are held stable until op_ready=1.
  - acc_clr=1 iff pair_cnt==0.
  - op_last=1 iff pair_cnt == latched_len-1, computed modulo 2^LEN_W, so len 0 gives last at 2^LEN_W-1.
  - Single-pair vector (len=1): acc_clr and op_last are both 1.
- Handshake (op_valid & op_ready): pair_cnt increments. If op_last, go to DONE; else go to A_LO.
- Latency: op_valid rises the cycle after the B_HI byte is accepted. Minimum 5 cycles per pair with back-to-back bytes and op_ready held high.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. pair_cnt retains its final value until the next start.
- pair_cnt wraps to 0 after 2^LEN_W-1. This occurs only on the final pair when len=0.
- abort=1 in any non-IDLE state: next state IDLE, op_valid drops, no done pulse. Partially assembled bytes are discarded; op_a/op_b keep their stale values. If abort and op_ready coincide in ISSUE, the handshake is not counted.
- Operands pass through bit-exact; the loader performs no arithmetic on them.

Optional Feature:
- Macro: DLFLOAT_SPECIAL_FLAG_EN.
- Defined:
  - Adds output port special_seen (1 bit), sticky.
  - Set when a handshaked pair has op_a==SPECIAL_VAL or op_b==SPECIAL_VAL.
  - Cleared on rst and on accepted start.
  - Readable through IDLE after DONE.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Single pair: start with vec_len=1; bytes 00,3E,00,40; op_ready=1.
  - op_valid rises 1 cycle after the 4th byte with op_a=16'h3E00, op_b=16'h4000, acc_clr=1, op_last=1.
  - done pulses 1 cycle after the handshake, then busy=0 and pair_cnt=1.
- Three-pair vector with op_ready held low for 4 cycles on pair 2.
  - op_a/op_b/op_valid stay stable throughout the stall; byte_ready=0 during the stall.
  - acc_clr only on pair 1, op_last only on pair 3, pair_cnt=3 at done.
- Gapped byte_valid (every other cycle): assembled operands are correct; state holds while byte_valid=0.
- vec_len=0 with LEN_W=8: 256 pairs issued; op_last only on pair 256; pair_cnt wraps to 0 at done.
- Abort: abort asserted in B_LO, then start a new len=1 vector.
  - No done pulse for the aborted vector; the new vector assembles from A_LO with acc_clr=1.
  - rst asserted in ISSUE clears op_valid and all outputs the next cycle.
- DLFLOAT_SPECIAL_FLAG_EN defined: pair with op_b=16'hFFFF sets special_seen after its handshake; it stays set through DONE and clears on the next start.
